// File: rtl/battleship_pkg.sv
// Shared types and constants for the battleship game controller.
package battleship_pkg;

    localparam int unsigned BOARD_N = 5;
    localparam int unsigned TW      = 26;

    typedef enum logic [2:0] {
        WATER = 3'b001,
        SHIP  = 3'b010,
        HIT   = 3'b111,
        NHIT  = 3'b100
    } cell_t;

    typedef enum logic [2:0] {
        IDLE,
        PLAYER_WAIT,
        PLAYER_SHOT,
        PC_WAIT,
        PC_SHOT,
        CHECK,
        GAME_OVER
    } turn_state_t;

    function automatic logic coord_ok(
        input logic [2:0] x,
        input logic [2:0] y,
        input logic [2:0] lim
    );
        return (x < lim) && (y < lim);
    endfunction

endpackage

// File: rtl/coord_lfsr.sv
// Free-running 8-bit LFSR that proposes a board coordinate every cycle
// and flags whether it lands on the board.
module coord_lfsr
    import battleship_pkg::*;
#(
    parameter int unsigned LIMIT = 5,
    parameter logic [7:0]  SEED  = 8'hA5
) (
    input  logic       clk,
    input  logic       rst_n,
    output logic [2:0] cand_x,
    output logic [2:0] cand_y,
    output logic       cand_ok
);

    localparam logic [2:0] LIM = 3'(LIMIT);

    logic [7:0] lfsr_q;
    logic       fb;

    // Taps 8,6,5,4 (maximal length)
    assign fb = lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            lfsr_q <= SEED;
        else
            lfsr_q <= {lfsr_q[6:0], fb};
    end

    assign cand_x  = lfsr_q[2:0];
    assign cand_y  = lfsr_q[5:3];
    assign cand_ok = coord_ok(cand_x, cand_y, LIM);

endmodule

// File: rtl/turn_scheduler.sv
// Turn scheduler: alternates player and PC shots into the board-update
// datapath and tracks hits until one side sinks every ship.
module turn_scheduler
    import battleship_pkg::*;
#(
    parameter int unsigned BOARD_N      = 5,
    parameter int unsigned SHIP_CELLS   = 5,
    parameter int unsigned TURN_TIMEOUT = 50_000_000,
    parameter int unsigned PC_DELAY     = 25_000_000,
    parameter logic [7:0]  LFSR_SEED    = 8'hA5
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic        fire,
    input  logic [2:0]  fire_x,
    input  logic [2:0]  fire_y,
    input  logic        shot_done,
    input  logic        shot_hit,
    input  logic        shot_repeat,
    output logic        turno,
    output logic        shot_valid,
    output logic [2:0]  shot_x,
    output logic [2:0]  shot_y,
    output logic        shot_target,
    output logic [2:0]  player_hits,
    output logic [2:0]  pc_hits,
    output logic        game_over,
    output logic        winner,
    output logic [25:0] timer
);

    localparam logic [2:0]    LIM    = 3'(BOARD_N);
    localparam logic [2:0]    H_MAX  = 3'(SHIP_CELLS);
    localparam logic [TW-1:0] T_LOAD = TW'(TURN_TIMEOUT - 1);
    localparam logic [TW-1:0] D_LOAD = TW'(PC_DELAY - 1);
    localparam logic [TW-1:0] ONE    = TW'(1);

    turn_state_t   state_q, state_d;
    logic          turno_q, turno_d;
    logic [TW-1:0] timer_q, timer_d;
    logic [TW-1:0] dly_q, dly_d;
    logic [2:0]    sx_q, sx_d;
    logic [2:0]    sy_q, sy_d;
    logic [2:0]    p_hits_q, p_hits_d;
    logic [2:0]    c_hits_q, c_hits_d;
    logic          win_q, win_d;

    logic [2:0] cand_x, cand_y;
    logic       cand_ok;
    logic       fire_ok;

    coord_lfsr #(
        .LIMIT (BOARD_N),
        .SEED  (LFSR_SEED)
    ) u_lfsr (
        .clk     (clk),
        .rst_n   (rst_n),
        .cand_x  (cand_x),
        .cand_y  (cand_y),
        .cand_ok (cand_ok)
    );

    assign fire_ok = fire && coord_ok(fire_x, fire_y, LIM);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            turno_q  <= 1'b1;
            timer_q  <= '0;
            dly_q    <= '0;
            sx_q     <= '0;
            sy_q     <= '0;
            p_hits_q <= '0;
            c_hits_q <= '0;
            win_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            turno_q  <= turno_d;
            timer_q  <= timer_d;
            dly_q    <= dly_d;
            sx_q     <= sx_d;
            sy_q     <= sy_d;
            p_hits_q <= p_hits_d;
            c_hits_q <= c_hits_d;
            win_q    <= win_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        turno_d  = turno_q;
        timer_d  = timer_q;
        dly_d    = dly_q;
        sx_d     = sx_q;
        sy_d     = sy_q;
        p_hits_d = p_hits_q;
        c_hits_d = c_hits_q;
        win_d    = win_q;
        unique case (state_q)
            IDLE, GAME_OVER: begin
                if (start) begin
                    state_d  = PLAYER_WAIT;
                    turno_d  = 1'b1;
                    timer_d  = T_LOAD;
                    p_hits_d = '0;
                    c_hits_d = '0;
                    win_d    = 1'b0;
                end
            end
            PLAYER_WAIT: begin
                if (timer_q != '0)
                    timer_d = timer_q - ONE;
                // A legal player fire beats the expiring auto-shot
                if (fire_ok) begin
                    sx_d    = fire_x;
                    sy_d    = fire_y;
                    state_d = PLAYER_SHOT;
                end else if (timer_q == '0 && cand_ok) begin
                    sx_d    = cand_x;
                    sy_d    = cand_y;
                    state_d = PLAYER_SHOT;
                end
            end
            PLAYER_SHOT: begin
                if (shot_done) begin
                    if (shot_repeat) begin
                        state_d = PLAYER_WAIT;
                    end else begin
                        if (shot_hit && p_hits_q < H_MAX)
                            p_hits_d = p_hits_q + 3'd1;
                        state_d = CHECK;
                    end
                end
            end
            CHECK: begin
                if (p_hits_q == H_MAX) begin
                    state_d = GAME_OVER;
                    win_d   = 1'b0;
                end else if (c_hits_q == H_MAX) begin
                    state_d = GAME_OVER;
                    win_d   = 1'b1;
                end else if (turno_q) begin
                    turno_d = 1'b0;
                    dly_d   = D_LOAD;
                    state_d = PC_WAIT;
                end else begin
                    turno_d = 1'b1;
                    timer_d = T_LOAD;
                    state_d = PLAYER_WAIT;
                end
            end
            PC_WAIT: begin
                if (dly_q != '0) begin
                    dly_d = dly_q - ONE;
                end else if (cand_ok) begin
                    sx_d    = cand_x;
                    sy_d    = cand_y;
                    state_d = PC_SHOT;
                end
            end
            PC_SHOT: begin
                if (shot_done) begin
                    if (shot_repeat) begin
                        dly_d   = '0;
                        state_d = PC_WAIT;
                    end else begin
                        if (shot_hit && c_hits_q < H_MAX)
                            c_hits_d = c_hits_q + 3'd1;
                        state_d = CHECK;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign turno       = turno_q;
    assign shot_valid  = (state_q == PLAYER_SHOT) || (state_q == PC_SHOT);
    assign shot_target = (state_q == PC_SHOT);
    assign shot_x      = sx_q;
    assign shot_y      = sy_q;
    assign player_hits = p_hits_q;
    assign pc_hits     = c_hits_q;
    assign game_over   = (state_q == GAME_OVER);
    assign winner      = win_q;
    assign timer       = timer_q;

endmodule

// File: doc/turn_scheduler.md
Name: turn_scheduler

Overview:
- Game-level controller that sequences the shot-update datapath between the human player and the PC.
- Runs the turn FSM and accepts the player's (x,y) fire request; generates PC shots from an LFSR and drives one shot at a time into the board-update datapath over a valid/done handshake.
- Counts hits per side and declares the winner; sits between the input/VGA front-end and the two 5x5 board-update blocks.

Parameters:
- BOARD_N, 5, board dimension; legal coordinates are 0..BOARD_N-1.
- SHIP_CELLS, 5, ship cells per board; reaching this hit count wins.
- TURN_TIMEOUT, 50_000_000, cycles the player may idle before an automatic shot.
- PC_DELAY, 25_000_000, cycles between the PC turn starting and its shot being issued.
- LFSR_SEED, 8'hA5, non-zero reset value of the 8-bit LFSR.

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- start  in  1  level; begins a game from IDLE or GAME_OVER
- fire  in  1  single-cycle player fire pulse
- fire_x  in  3  player target row
- fire_y  in  3  player target column
- shot_done  in  1  datapath finished the current shot (1-cycle pulse)
- shot_hit  in  1  valid with shot_done; target cell was SHIP
- shot_repeat  in  1  valid with shot_done; target cell already HIT/NHIT, board unchanged
- turno  out  1  1 = player turn, 0 = PC turn
- shot_valid  out  1  shot request to datapath
- shot_x  out  3  shot row
- shot_y  out  3  shot column
- shot_target  out  1  0 = PC board, 1 = player board
- player_hits  out  3  hits scored by player
- pc_hits  out  3  hits scored by PC
- game_over  out  1  game finished
- winner  out  1  0 = player, 1 = PC; valid while game_over
- timer  out  26  remaining cycles of the current player turn

Behaviour:
- Reset (async, rst_n=0): state IDLE. All outputs 0 except turno=1. LFSR=LFSR_SEED; counters cleared.
- LFSR: 8-bit Fibonacci, taps 8,6,5,4; advances every cycle in every state except reset. Candidate PC coordinate is {lfsr[2:0], lfsr[5:3]}.
- IDLE: on start=1, clear hit counters and set timer=TURN_TIMEOUT-1 -> PLAYER_WAIT.
- PLAYER_WAIT (turno=1): timer decrements each cycle.
  - fire=1 with fire_x<BOARD_N and fire_y<BOARD_N: latch the coordinates -> PLAYER_SHOT.
  - Out-of-range fire: ignored.
  - timer==0 with no legal fire: latch the LFSR candidate, using it only if in range; otherwise continue advancing, one attempt per cycle -> PLAYER_SHOT.
  - A legal fire in the same cycle as timer==0 wins over the auto-shot.
- PLAYER_SHOT: shot_valid=1, shot_target=0; shot_x/shot_y held stable until shot_done. fire is ignored.
  - On shot_done with shot_repeat=1: back to PLAYER_WAIT; the timer is not reloaded. An auto-shot repeat retries the next cycle.
  - On shot_hit=1: player_hits+1.
  - Otherwise: -> CHECK.
- CHECK (1 cycle): player_hits==SHIP_CELLS -> GAME_OVER, winner=0. pc_hits==SHIP_CELLS -> GAME_OVER, winner=1. Else toggle turno: to PC -> PC_WAIT with delay counter=PC_DELAY-1; to player -> PLAYER_WAIT with timer reloaded.
- PC_WAIT (turno=0): count down; at 0, latch the first in-range LFSR candidate -> PC_SHOT.
- PC_SHOT: shot_valid=1, shot_target=1.
  - shot_repeat: back to PC_WAIT with delay counter=0, so a new candidate is drawn next cycle.
  - Hit: pc_hits+1 -> CHECK.
  - Miss: -> CHECK.
- Turns strictly alternate; a hit does not grant an extra shot.
- GAME_OVER: game_over=1, shot_valid=0. Counters and winner frozen. start=1 -> behaves as IDLE+start.
- Handshake: shot_valid asserts the cycle after entering a *_SHOT state and deasserts the cycle after shot_done. shot_done with shot_valid=0 is ignored.
- Hit counters saturate at SHIP_CELLS.
- Reset mid-shot aborts immediately; shot_valid=0 asynchronously.

Decomposition:
- Package battleship_pkg:
  - cell codes WATER=3'b001, SHIP=3'b010, HIT=3'b111, NHIT=3'b100
  - BOARD_N
  - state enum turn_state_t {IDLE, PLAYER_WAIT, PLAYER_SHOT, PC_WAIT, PC_SHOT, CHECK, GAME_OVER}
- One sub-module: coord_lfsr (8-bit LFSR plus in-range candidate qualifier). Instantiated once and shared by the auto-shot and PC-shot paths.

Test Plan:
- Reset, then start, then fire (2,3), then shot_done with hit=1 -> shot_x=2, shot_y=3, shot_target=0, player_hits=1, turno=0 two cycles after shot_done.
- fire (5,1) in PLAYER_WAIT -> no shot_valid, state stays PLAYER_WAIT, timer keeps decrementing.
- TURN_TIMEOUT=16, no fire -> shot_valid within 17+k cycles, where k is the number of rejected out-of-range candidates; coordinates both <5, shot_target=0.
- PC shot answered with shot_repeat twice, then a miss -> three shot_valid requests, pc_hits unchanged, turno=1 after CHECK.
- Player scores 5 hits over alternating turns -> game_over=1, winner=0, later fire pulses ignored; start=1 clears hits and turno=1.
- rst_n deasserted while shot_valid=1 -> shot_valid=0 with no clock edge; all outputs at reset values.
